// File: rtl/debug_display_scanner.sv
// debug_display_scanner
//   Board-side debug front end for the data-memory debug port.
//   Raw switches are synchronised and debounced into the debug read address.
//   The returned debug word is latched once per display frame and shown as
//   four hex digits on a time-multiplexed, active-low 7-segment display.
//
//   Optional feature (macro DEBUG_AUTOSCAN_EN): when defined, a synchronised
//   auto_scan request sweeps the debug address through the whole range,
//   dwelling SCAN_CYCLES on each location, and lights the decimal point of
//   the most significant digit while sweeping. When undefined, auto_scan is
//   ignored and dp stays off.
//
//   DEBOUNCE_CYCLES must be at least 2 and REFRESH_CYCLES at least 1.
//   DATA_W is expected to be 16 (four displayed nibbles).
module debug_display_scanner #(
    parameter int ADDR_W          = 7,
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] sw,
    input  logic              auto_scan,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W = $clog2(REFRESH_CYCLES + 1);

    // Stable value is accepted on the same edge the counter reaches
    // DEBOUNCE_CYCLES-1, so the comparison is against the value one below.
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_CYCLES - 1);

    // ------------------------------------------------------------------
    // Switch synchroniser and debouncer state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] sw_meta_reg;
    logic [ADDR_W-1:0] sw_sync_reg;
    logic [ADDR_W-1:0] candidate_reg;
    logic [ADDR_W-1:0] stable_reg;
    logic [DCNT_W-1:0] dcnt_reg;

    // ------------------------------------------------------------------
    // Display refresh state
    // ------------------------------------------------------------------
    logic [RCNT_W-1:0] rcnt_reg;
    logic [1:0]        idx_reg;
    logic [DATA_W-1:0] disp_reg;

    // Next values for the registered outputs
    logic [ADDR_W-1:0] addr_next;
    logic [3:0]        an_next;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [3:0]        nibble;

    // Two-flop synchroniser for the asynchronous switch bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // Debounce: any change restarts the count; a candidate that survives
    // DEBOUNCE_CYCLES consecutive cycles becomes the stable address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate_reg <= '0;
            stable_reg    <= '0;
            dcnt_reg      <= '0;
        end else if (sw_sync_reg != candidate_reg) begin
            candidate_reg <= sw_sync_reg;
            dcnt_reg      <= '0;
        end else if (candidate_reg != stable_reg) begin
            dcnt_reg <= dcnt_reg + 1'b1;
            if (dcnt_reg == DCNT_LAST) begin
                stable_reg <= candidate_reg;
            end
        end
    end

    // Refresh timer, digit index and once-per-frame latch of the debug word;
    // latching only on the 3->0 wrap keeps one frame free of tearing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_reg <= '0;
            idx_reg  <= '0;
            disp_reg <= '0;
        end else if (rcnt_reg == RCNT_LAST) begin
            rcnt_reg <= '0;
            idx_reg  <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
                disp_reg <= debug_data;
            end
        end else begin
            rcnt_reg <= rcnt_reg + 1'b1;
        end
    end

`ifdef DEBUG_AUTOSCAN_EN
    localparam int SCNT_W = $clog2(SCAN_CYCLES + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCAN_CYCLES - 1);

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_t;

    logic              as_meta_reg;
    logic              as_sync_reg;
    mode_t             mode_reg;
    logic [ADDR_W-1:0] scan_addr_reg;
    logic [SCNT_W-1:0] scnt_reg;

    // Two-flop synchroniser for the auto-scan request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            as_meta_reg <= 1'b0;
            as_sync_reg <= 1'b0;
        end else begin
            as_meta_reg <= auto_scan;
            as_sync_reg <= as_meta_reg;
        end
    end

    // Mode FSM: entering auto mode seeds the sweep from the stable address,
    // then the address advances every SCAN_CYCLES and wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg      <= MODE_MANUAL;
            scan_addr_reg <= '0;
            scnt_reg      <= '0;
        end else begin
            case (mode_reg)
                MODE_MANUAL: begin
                    if (as_sync_reg) begin
                        mode_reg      <= MODE_AUTO;
                        scan_addr_reg <= stable_reg;
                        scnt_reg      <= '0;
                    end
                end
                MODE_AUTO: begin
                    if (!as_sync_reg) begin
                        mode_reg <= MODE_MANUAL;
                        scnt_reg <= '0;
                    end else if (scnt_reg == SCNT_LAST) begin
                        scnt_reg      <= '0;
                        scan_addr_reg <= scan_addr_reg + 1'b1;
                    end else begin
                        scnt_reg <= scnt_reg + 1'b1;
                    end
                end
                default: mode_reg <= MODE_MANUAL;
            endcase
        end
    end

    // Address source and decimal point in auto mode; dropping the request
    // falls back to the stable address on the very next output update
    always_comb begin
        addr_next = stable_reg;
        dp_next   = 1'b1;
        if (mode_reg == MODE_AUTO && as_sync_reg) begin
            addr_next = scan_addr_reg;
        end
        if (mode_reg == MODE_AUTO && idx_reg == 2'd3) begin
            dp_next = 1'b0;
        end
    end
`else
    logic unused_auto_scan;
    assign unused_auto_scan = auto_scan;

    // Manual-only build: address always follows the debounced switches
    always_comb begin
        addr_next = stable_reg;
        dp_next   = 1'b1;
    end
`endif

    // One-hot-low digit enable derived from the current index
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign an_next[gi] = (idx_reg != 2'(gi));
        end
    endgenerate

    // Hex to 7-segment ({g,f,e,d,c,b,a}, active-low) for the selected nibble
    always_comb begin
        nibble   = disp_reg[4*idx_reg +: 4];
        seg_next = 7'h7F;
        case (nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'h7F;
        endcase
    end

    // Registered outputs: display lags the index by one cycle, blank in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debug_addr <= '0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            debug_addr <= addr_next;
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
        end
    end

endmodule

// File: tb/tb_debug_display_scanner.sv
// tb_debug_display_scanner
//   Directed bench for debug_display_scanner with short debounce, refresh and
//   scan periods. Expected values are hand-computed constants.
module tb_debug_display_scanner;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] sw;
    logic              auto_scan;
    logic [ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0] debug_data;
    logic [6:0]        seg;
    logic [3:0]        an;
    logic              dp;

    int checks;
    int errors;

    debug_display_scanner #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .DEBOUNCE_CYCLES (4),
        .REFRESH_CYCLES  (3),
        .SCAN_CYCLES     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .auto_scan  (auto_scan),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .seg        (seg),
        .an         (an),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Wait (bounded) until the given digit enable is showing, then record it
    task automatic wait_an(input logic [3:0] val, input string tag);
        int n;
        n = 0;
        while (an !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {28'd0, an}, {28'd0, val});
    endtask

    // Safety net against a stuck simulation
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] an_exp  [4];
    logic [6:0] seg_exp [4];

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        sw         = 7'h55;
        auto_scan  = 1'b0;
        debug_data = 16'h0000;

        // 1. Reset held: outputs at reset values throughout
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_addr", {25'd0, debug_addr}, 32'h00);
            check("rst_an",   {28'd0, an},         32'hF);
            check("rst_seg",  {25'd0, seg},        32'h7F);
            check("rst_dp",   {31'd0, dp},         32'h1);
        end
        sw    = 7'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 2. Debounce accept: edge -> address seven cycles later
        sw = 7'h05;
        repeat (6) @(negedge clk);
        check("deb_early",  {25'd0, debug_addr}, 32'h00);
        @(negedge clk);
        check("deb_accept", {25'd0, debug_addr}, 32'h05);
        repeat (3) @(negedge clk);
        // Two-cycle glitch is rejected
        sw = 7'h7F;
        repeat (2) @(negedge clk);
        sw = 7'h05;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("deb_glitch", {25'd0, debug_addr}, 32'h05);
        end

        // 3. Digit scan of 0xA3C1, each digit held three cycles
        debug_data = 16'hA3C1;
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'b1111001, 7'b1000110, 7'b0110000, 7'b0001000};
        wait_an(4'b0111, "scan_sync3");
        wait_an(4'b1110, "scan_sync0");
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) begin
                check("scan_an",  {28'd0, an},  {28'd0, an_exp[d]});
                check("scan_seg", {25'd0, seg}, {25'd0, seg_exp[d]});
                @(negedge clk);
            end
        end

        // 4. Frame latch: data changes while digit 2 is lit
        debug_data = 16'h1234;
        wait_an(4'b0111, "latch_sync3");
        wait_an(4'b1110, "latch_sync0");
        check("latch_d0", {25'd0, seg}, {25'd0, 7'b0011001});
        wait_an(4'b1011, "latch_an2");
        debug_data = 16'hABCD;
        check("latch_d2_old", {25'd0, seg}, {25'd0, 7'b0100100});
        wait_an(4'b0111, "latch_an3");
        check("latch_d3_old", {25'd0, seg}, {25'd0, 7'b1111001});
        wait_an(4'b1110, "latch_an0n");
        check("latch_d0_new", {25'd0, seg}, {25'd0, 7'b0100001});
        wait_an(4'b1101, "latch_an1n");
        check("latch_d1_new", {25'd0, seg}, {25'd0, 7'b1000110});
        wait_an(4'b1011, "latch_an2n");
        check("latch_d2_new", {25'd0, seg}, {25'd0, 7'b0000011});
        wait_an(4'b0111, "latch_an3n");
        check("latch_d3_new", {25'd0, seg}, {25'd0, 7'b0001000});

        // 5. Auto-scan request
        sw = 7'h7F;
        repeat (10) @(negedge clk);
        check("as_base", {25'd0, debug_addr}, 32'h7F);
        auto_scan = 1'b1;
`ifdef DEBUG_AUTOSCAN_EN
        begin
            int n;
            n = 0;
            while (debug_addr === 7'h7F && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("as_wrap", {25'd0, debug_addr}, 32'h00);
        end
        wait_an(4'b0111, "as_an3");
        check("as_dp_on", {31'd0, dp}, 32'h0);
        wait_an(4'b1110, "as_an0");
        check("as_dp_off", {31'd0, dp}, 32'h1);
        auto_scan = 1'b0;
        repeat (4) @(negedge clk);
        check("as_return", {25'd0, debug_addr}, 32'h7F);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("as_addr", {25'd0, debug_addr}, 32'h7F);
            check("as_dp",   {31'd0, dp},         32'h1);
        end
        auto_scan = 1'b0;
`endif
        repeat (4) @(negedge clk);

        // 6. Reset pulse in the middle of a debounce
        sw = 7'h22;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rp_addr", {25'd0, debug_addr}, 32'h00);
        check("rp_an",   {28'd0, an},         32'hF);
        check("rp_seg",  {25'd0, seg},        32'h7F);
        check("rp_dp",   {31'd0, dp},         32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rp_first_an",  {28'd0, an},  32'hE);
        check("rp_first_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        repeat (5) @(negedge clk);
        check("rp_deb_early",  {25'd0, debug_addr}, 32'h00);
        @(negedge clk);
        check("rp_deb_accept", {25'd0, debug_addr}, 32'h22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
